fetch_unit: RTL
===============

# fetch_unit

Instruction fetch stage that sits directly upstream of the datapath and supplies it with one 32-bit instruction and its PC per handshake. It owns the fetch PC and issues requests to a variable-latency instruction memory over a valid/ready request channel and an in-order response channel. It buffers returned instructions in a small FIFO, so that memory latency and downstream stalls are decoupled. It accepts a redirect (branch/jump) that flushes in-flight and buffered instructions and restarts fetch at a new address.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- DEPTH, 2, FIFO entries and max in-flight requests (power of two, >= 2)

- clock  in  1  rising-edge clock
- resetN  in  1  synchronous, active-low reset
- memReqValid  out  1  request valid
- memReqAddr  out  32  request word address
- memReqReady  in  1  memory accepts request
- memRespValid  in  1  response valid, one per accepted request, in order
- memRespData  in  32  instruction word
- redirectValid  in  1  redirect strobe (single cycle)
- redirectPc  in  32  new fetch address
- instValid  out  1  instruction available to datapath
- instData  out  32  instruction at FIFO head
- instPc  out  32  PC of instData
- instReady  in  1  datapath consumes head

## Operation
- Registers: fetchPc (next request address), respPc (PC of next kept response), outstanding (0..DEPTH), staleCount (0..DEPTH), FIFO of {pc, inst}, state.
- States: RUN, DRAIN. Reset -> RUN.
- RUN: memReqValid = (outstanding + fifoCount) < DEPTH. memReqAddr = fetchPc. Request accepted on memReqValid && memReqReady: fetchPc += 4, outstanding += 1.
- Response with outstanding > 0 and staleCount == 0: push {respPc, memRespData}, respPc += 4, outstanding -= 1. Credit rule guarantees the FIFO never overflows.
- memRespValid while outstanding == 0 is ignored.
- Pop on instValid && instReady. Push and pop in the same cycle are both performed.
- Redirect (highest priority):
  - FIFO flushed.
  - fetchPc and respPc <= {redirectPc[31:2], 2'b00}.
  - staleCount <= outstanding + (request accepted this cycle) − (response this cycle).
  - A pop in the same cycle is discarded.
  - Next state is DRAIN if staleCount != 0, else RUN.
- DRAIN: memReqValid = 0. Each response decrements both staleCount and outstanding and is not pushed. When staleCount reaches 0, go to RUN. A redirect in DRAIN recomputes staleCount the same way.
- An unaccepted request may change address on redirect. Otherwise memReqAddr is stable while memReqValid && !memReqReady.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0.

## Timing
- Reset values:
  - memReqValid = 0, memReqAddr = RESET_PC.
  - instValid = 0, instData = 32'h0, instPc = 32'h0.
  - FIFO empty, outstanding = staleCount = 0, state = RUN.
- First memReqValid is in the first cycle with resetN high.
- Response-to-instValid latency: 1 cycle (push at edge, head visible next cycle).
- Redirect-to-new-request latency: next cycle if no stale requests, else the cycle after the last stale response.
- instValid drops the cycle after a redirect.
- Zero-wait memory (ready = 1, response one cycle after acceptance) plus instReady = 1 sustains 1 instruction/cycle for DEPTH >= 2.
- resetN low mid-operation discards everything in the following cycle; the memory is reset by the same resetN.

## Structure
- Shared package riscx_pkg holds:
  - XLEN = 32.
  - RESET_PC default.
  - NOP = 32'h0000_0013.
  - The state enum {RUN, DRAIN}.
- Sub-module fetch_fifo: synchronous FIFO of width 64, depth DEPTH, with flush, push, pop, full, empty, count and head outputs. The fetch_unit holds the PC, credit and FSM logic.

## Test plan
- Reset, zero-wait memory, instReady = 1 -> instPc 0x0, 0x4, 0x8 … on consecutive cycles, instData matches memory, no gaps after the first.
- instReady = 0 for 10 cycles -> exactly DEPTH requests issued, memReqValid then low, FIFO holds PCs 0x0 and 0x4. Release -> both delivered in order, then fetch resumes at 0x8.
- 3-cycle memory, redirect to 0x100 with 2 requests in flight -> state DRAIN, 2 stale responses dropped, no memReqValid until drained, next instPc = 0x100.
- Redirect to 0x103 -> memReqAddr = 0x100, instPc = 0x100.
- Redirect to 0xFFFF_FFFC -> instPc 0xFFFF_FFFC, then 0x0.
- Redirect coincident with a push, a pop and a request acceptance -> nothing stale is delivered, staleCount correct, first delivered instPc = redirect target. resetN low with 2 outstanding -> all outputs at reset values, late memRespValid ignored.

Source files
------------

// File: rtl/riscx_pkg.sv
// Shared core types and constants.
// Used by the fetch stage and its FIFO.
package riscx_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC =
    32'h0000_0000;

  localparam logic [XLEN-1:0] NOP =
    32'h0000_0013;

  typedef enum logic {
    RUN,
    DRAIN
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } if_id_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory request/response channel.
// Master is the fetch stage, slave is the memory.
interface fetch_unit_if;
  import riscx_pkg::*;

  logic            memReqValid;
  logic [XLEN-1:0] memReqAddr;
  logic            memReqReady;
  logic            memRespValid;
  logic [XLEN-1:0] memRespData;

  modport master (
    output memReqValid,
    output memReqAddr,
    input  memReqReady,
    input  memRespValid,
    input  memRespData
  );

  modport slave (
    input  memReqValid,
    input  memReqAddr,
    output memReqReady,
    output memRespValid,
    output memRespData
  );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous {pc, inst} FIFO with flush.
// Head reads as zero while empty.
module fetch_fifo
  import riscx_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clock,
  input  logic                   resetN,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  if_id_t                 din,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output if_id_t                 head
);

  localparam int AW = $clog2(DEPTH);

  if_id_t          mem [DEPTH];
  logic [AW-1:0]   rdPtr;
  logic [AW-1:0]   wrPtr;
  logic [AW:0]     cnt;
  logic            doPush;
  logic            doPop;

  assign full   = (cnt == (AW+1)'(DEPTH));
  assign empty  = (cnt == '0);
  assign count  = cnt;
  assign doPush = push && !full;
  assign doPop  = pop && !empty;
  assign head   = empty ? '0 : mem[rdPtr];

  always_ff @(posedge clock) begin
    if (!resetN || flush) begin
      rdPtr <= '0;
      wrPtr <= '0;
      cnt   <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      unique case ({doPush, doPop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (doPush) mem[wrPtr] <= din;
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC, request credits, redirect
// drain FSM and the instruction buffer.
module fetch_unit
  import riscx_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC =
    riscx_pkg::RESET_PC,
  parameter int DEPTH = 2
) (
  input  logic            clock,
  input  logic            resetN,
  fetch_unit_if.master    mem,
  input  logic            redirectValid,
  input  logic [XLEN-1:0] redirectPc,
  output logic            instValid,
  output logic [XLEN-1:0] instData,
  output logic [XLEN-1:0] instPc,
  input  logic            instReady
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int FW = $clog2(DEPTH) + 1;

  fetch_state_t    state;
  fetch_state_t    stateN;
  logic [XLEN-1:0] fetchPc;
  logic [XLEN-1:0] fetchPcN;
  logic [XLEN-1:0] respPc;
  logic [XLEN-1:0] respPcN;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   outstandingN;
  logic [CW-1:0]   staleCount;
  logic [CW-1:0]   staleCountN;
  logic [FW-1:0]   fifoCount;
  logic [CW:0]     credit;
  logic [XLEN-1:0] redirAligned;
  logic            fifoFull;
  logic            fifoEmpty;
  logic            reqFire;
  logic            respFire;
  logic            popReq;
  logic            push;
  logic            pop;
  if_id_t          head;
  if_id_t          pushEntry;

  assign redirAligned = {redirectPc[XLEN-1:2], 2'b00};
  assign popReq = instValid && instReady;

  // A head leaving this cycle frees its slot,
  // which keeps the zero-wait loop at 1 IPC.
  assign credit = (CW+1)'(outstanding)
                + (CW+1)'(fifoCount)
                - (CW+1)'(popReq);

  assign mem.memReqValid = resetN
                        && (state == RUN)
                        && (credit < (CW+1)'(DEPTH));
  assign mem.memReqAddr  = fetchPc;

  assign reqFire  = mem.memReqValid
                 && mem.memReqReady;
  assign respFire = mem.memRespValid
                 && (outstanding != '0);
  assign push     = respFire
                 && (state == RUN)
                 && (staleCount == '0)
                 && !redirectValid;
  assign pop      = popReq && !redirectValid;

  assign pushEntry.pc   = respPc;
  assign pushEntry.inst = mem.memRespData;

  always_comb begin
    stateN       = state;
    fetchPcN     = fetchPc;
    respPcN      = respPc;
    staleCountN  = staleCount;
    outstandingN = outstanding
                 + CW'(reqFire)
                 - CW'(respFire);
    if (reqFire) fetchPcN = fetchPc + 32'd4;
    if (push)    respPcN  = respPc + 32'd4;
    unique case (1'b1)
      redirectValid: begin
        fetchPcN    = redirAligned;
        respPcN     = redirAligned;
        staleCountN = outstandingN;
        stateN      = (outstandingN != '0)
                    ? DRAIN : RUN;
      end
      (!redirectValid && state == DRAIN): begin
        if (respFire)
          staleCountN = staleCount - 1'b1;
        if (staleCountN == '0)
          stateN = RUN;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetN) begin
      state       <= RUN;
      fetchPc     <= RESET_PC;
      respPc      <= RESET_PC;
      outstanding <= '0;
      staleCount  <= '0;
    end else begin
      state       <= stateN;
      fetchPc     <= fetchPcN;
      respPc      <= respPcN;
      outstanding <= outstandingN;
      staleCount  <= staleCountN;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock  (clock),
    .resetN (resetN),
    .flush  (redirectValid),
    .push   (push),
    .pop    (pop),
    .din    (pushEntry),
    .full   (fifoFull),
    .empty  (fifoEmpty),
    .count  (fifoCount),
    .head   (head)
  );

  assign instValid = !fifoEmpty;
  assign instData  = head.inst;
  assign instPc    = head.pc;

endmodule
